// File: rtl/bonus_hit_ctrl_pkg.sv
// rtl/bonus_hit_ctrl_pkg.sv - shared types and constants for bonus_hit_ctrl
// Purpose: FSM state encoding, score width, shot counter limit and the
//          per-shot bonus score table used when BONUS_SHOT_TABLE_EN is set.
// Ports:   none (package).
package bonus_hit_pkg;

  localparam int SCORE_W      = 9;
  localparam int SHOT_CNT_MAX = 14;
  localparam int SHOT_CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ARMED       = 2'd1,
    HIT_PENDING = 2'd2,
    FLASH       = 2'd3
  } state_t;

  typedef logic [SCORE_W-1:0] score_t;

  // Score awarded for a hit, indexed by the number of shots fired (mod 15).
  localparam score_t SCORE_TABLE [0:SHOT_CNT_MAX] = '{
    9'd50,  9'd100, 9'd150, 9'd200, 9'd250,
    9'd300, 9'd300, 9'd250, 9'd200, 9'd150,
    9'd100, 9'd50,  9'd50,  9'd100, 9'd150
  };

endpackage

// File: rtl/bonus_hit_ctrl_if.sv
// rtl/bonus_hit_ctrl_if.sv - frame/pixel/score signal bundle for bonus_hit_ctrl
// Purpose: groups the frame timing, drawing-request, fire and hit/score
//          signals of the bonus hit controller.
// Ports (slave = controller side):
//   inputs : startOfFrame, playGame, bonus_ship_DR, playerShot_DR, playerFire
//   outputs: bonusFireCollision, scoreValid, bonusScore[8:0], hitFlash
interface bonus_hit_ctrl_if;
  import bonus_hit_pkg::*;

  logic   startOfFrame;
  logic   playGame;
  logic   bonus_ship_DR;
  logic   playerShot_DR;
  logic   playerFire;
  logic   bonusFireCollision;
  logic   scoreValid;
  score_t bonusScore;
  logic   hitFlash;

  modport master (
    output startOfFrame, playGame, bonus_ship_DR, playerShot_DR, playerFire,
    input  bonusFireCollision, scoreValid, bonusScore, hitFlash
  );

  modport slave (
    input  startOfFrame, playGame, bonus_ship_DR, playerShot_DR, playerFire,
    output bonusFireCollision, scoreValid, bonusScore, hitFlash
  );

endinterface

// File: rtl/bonus_hit_ctrl_score_lut.sv
// rtl/bonus_hit_ctrl_score_lut.sv - shot count to bonus score lookup
// Purpose: combinational map shot_cnt -> SCORE_TABLE entry. Only present
//          when BONUS_SHOT_TABLE_EN is defined.
// Ports:
//   shot_cnt [3:0] in  : shots fired so far (0..14)
//   score    [8:0] out : points for a hit at this shot count
`ifdef BONUS_SHOT_TABLE_EN
module bonus_score_lut
  import bonus_hit_pkg::*;
(
  input  logic [SHOT_CNT_W-1:0] shot_cnt,
  output score_t                score
);

  always_comb begin
    score = '0;
    // Counter never exceeds SHOT_CNT_MAX; the guard keeps code 15 defined.
    if (shot_cnt <= SHOT_CNT_W'(SHOT_CNT_MAX)) begin
      score = SCORE_TABLE[shot_cnt];
    end
  end

endmodule
`endif

// File: rtl/bonus_hit_ctrl.sv
// rtl/bonus_hit_ctrl.sv - bonus ship hit detection, scoring and explosion flash
// Purpose: detects a bonus-ship / player-shot pixel overlap, commits the hit
//          at the next frame start (collision + score pulse) and holds the
//          explosion flash for FLASH_FRAMES frames.
// Optional feature: BONUS_SHOT_TABLE_EN selects a shot-count dependent score
//          from SCORE_TABLE; otherwise FIXED_SCORE is awarded.
// Ports:
//   clk   in : system clock
//   reset in : asynchronous, active-high reset
//   bus      : bonus_hit_ctrl_if.slave (frame/pixel inputs, hit/score outputs)
module bonus_hit_ctrl
  import bonus_hit_pkg::*;
#(
  parameter int FLASH_FRAMES = 16,
  parameter int FIXED_SCORE  = 100
) (
  input  logic             clk,
  input  logic             reset,
  bonus_hit_ctrl_if.slave  bus
);

  localparam logic [7:0] FLASH_LOAD = 8'(FLASH_FRAMES - 1);

  state_t     state, state_nxt;
  logic [7:0] flash_cnt, flash_cnt_nxt;
  logic       hit_flash, hit_flash_nxt;
  logic       collision, collision_nxt;
  logic       score_valid, score_valid_nxt;
  score_t     bonus_score, bonus_score_nxt;
  score_t     award;
  logic       overlap;

  assign overlap = bus.bonus_ship_DR & bus.playerShot_DR;

`ifdef BONUS_SHOT_TABLE_EN
  logic [SHOT_CNT_W-1:0] shot_cnt;

  // The LUT reads the registered count, so a playerFire in the commit clk
  // only affects later hits.
  bonus_score_lut u_score_lut (
    .shot_cnt (shot_cnt),
    .score    (award)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shot_cnt <= '0;
    end else if (!bus.playGame) begin
      shot_cnt <= '0;
    end else if (bus.playerFire) begin
      shot_cnt <= (shot_cnt == SHOT_CNT_W'(SHOT_CNT_MAX)) ? '0
                                                          : shot_cnt + SHOT_CNT_W'(1);
    end
  end
`else
  assign award = SCORE_W'(FIXED_SCORE);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      flash_cnt   <= '0;
      hit_flash   <= 1'b0;
      collision   <= 1'b0;
      score_valid <= 1'b0;
      bonus_score <= '0;
    end else begin
      state       <= state_nxt;
      flash_cnt   <= flash_cnt_nxt;
      hit_flash   <= hit_flash_nxt;
      collision   <= collision_nxt;
      score_valid <= score_valid_nxt;
      bonus_score <= bonus_score_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    flash_cnt_nxt   = flash_cnt;
    hit_flash_nxt   = hit_flash;
    collision_nxt   = 1'b0;
    score_valid_nxt = 1'b0;
    bonus_score_nxt = bonus_score;

    if (!bus.playGame) begin
      // Game over overrides everything, including a pending hit.
      state_nxt       = IDLE;
      flash_cnt_nxt   = '0;
      hit_flash_nxt   = 1'b0;
      bonus_score_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.startOfFrame) state_nxt = ARMED;
        end
        ARMED: begin
          // An overlap coinciding with startOfFrame only arms the hit;
          // the commit waits for the following frame start.
          if (overlap) state_nxt = HIT_PENDING;
        end
        HIT_PENDING: begin
          if (bus.startOfFrame) begin
            collision_nxt   = 1'b1;
            score_valid_nxt = 1'b1;
            bonus_score_nxt = award;
            hit_flash_nxt   = 1'b1;
            flash_cnt_nxt   = FLASH_LOAD;
            state_nxt       = FLASH;
          end
        end
        FLASH: begin
          if (bus.startOfFrame) begin
            if (flash_cnt != 8'd0) begin
              flash_cnt_nxt = flash_cnt - 8'd1;
            end else begin
              hit_flash_nxt = 1'b0;
              state_nxt     = ARMED;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign bus.bonusFireCollision = collision;
  assign bus.scoreValid         = score_valid;
  assign bus.bonusScore         = bonus_score;
  assign bus.hitFlash           = hit_flash;

endmodule

// File: tb/tb_bonus_hit_ctrl.sv
// tb/tb_bonus_hit_ctrl.sv - self-checking bench for bonus_hit_ctrl
module tb_bonus_hit_ctrl;
  import bonus_hit_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  bonus_hit_ctrl_if bus();

  bonus_hit_ctrl #(
    .FLASH_FRAMES (16),
    .FIXED_SCORE  (100)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef BONUS_SHOT_TABLE_EN
  logic [8:0] exp_tab [15] = '{
    9'd50,  9'd100, 9'd150, 9'd200, 9'd250,
    9'd300, 9'd300, 9'd250, 9'd200, 9'd150,
    9'd100, 9'd50,  9'd50,  9'd100, 9'd150
  };
`endif

  function automatic logic [8:0] exp_score(int k);
`ifdef BONUS_SHOT_TABLE_EN
    return exp_tab[k];
`else
    return (k >= 0) ? 9'd100 : 9'd100;
`endif
  endfunction

  typedef struct packed {
    logic       sof;
    logic       play;
    logic       ship;
    logic       shot;
    logic       fire;
    logic       col;
    logic       valid;
    logic       flash;
    logic [8:0] score;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(string nm, logic [15:0] got, logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", nm, got, exp);
    end
  endtask

  task automatic chk_outs(string nm, logic col, logic valid, logic flash, logic [8:0] score);
    chk({nm, ".col"},   16'(bus.bonusFireCollision), 16'(col));
    chk({nm, ".valid"}, 16'(bus.scoreValid),         16'(valid));
    chk({nm, ".flash"}, 16'(bus.hitFlash),           16'(flash));
    chk({nm, ".score"}, 16'(bus.bonusScore),         16'(score));
  endtask

  task automatic step(logic sof, logic play, logic ship, logic shot, logic fire);
    @(negedge clk);
    bus.startOfFrame  = sof;
    bus.playGame      = play;
    bus.bonus_ship_DR = ship;
    bus.playerShot_DR = shot;
    bus.playerFire    = fire;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // n frames of (frame start + one idle clk); optionally require no hit pulse
  task automatic frames(int n, logic chk_nocol, string nm);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      if (chk_nocol) chk(nm, 16'(bus.bonusFireCollision), 16'd0);
      idle();
      if (chk_nocol) chk(nm, 16'(bus.bonusFireCollision), 16'd0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.startOfFrame  = 1'b0;
    bus.bonus_ship_DR = 1'b0;
    bus.playerShot_DR = 1'b0;
    bus.playerFire    = 1'b0;
    bus.playGame      = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset             = 1'b1;
    bus.startOfFrame  = 1'b0;
    bus.playGame      = 1'b0;
    bus.bonus_ship_DR = 1'b0;
    bus.playerShot_DR = 1'b0;
    bus.playerFire    = 1'b0;

    //                 sof play ship shot fire col val fl  score
    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, exp_score(0)};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, exp_score(0)};
    vecs[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, exp_score(0)};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk_outs("reset", 1'b0, 1'b0, 1'b0, 9'd0);
    @(negedge clk);
    reset = 1'b0;

    // basic hit sequence from IDLE
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].sof, vecs[i].play, vecs[i].ship, vecs[i].shot, vecs[i].fire);
      chk_outs($sformatf("vec%0d", i), vecs[i].col, vecs[i].valid, vecs[i].flash, vecs[i].score);
    end

    // flash spans 16 frames: 15 decrementing frame starts, the 16th clears
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk($sformatf("flash_sof%0d", i), 16'(bus.hitFlash), (i < 16) ? 16'd1 : 16'd0);
      chk($sformatf("flash_col%0d", i), 16'(bus.bonusFireCollision), 16'd0);
      idle();
      idle();
    end

    // overlap seen during FLASH left nothing pending
    frames(2, 1'b1, "no_hit_from_flash_overlap");

    // fresh overlap after FLASH -> new pulse, exactly at the next frame start
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("overlap2_col", 16'(bus.bonusFireCollision), 16'd0);
    idle();
    chk("pending2_col", 16'(bus.bonusFireCollision), 16'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_outs("hit2", 1'b1, 1'b1, 1'b1, exp_score(0));
    idle();
    chk_outs("hit2_after", 1'b0, 1'b0, 1'b1, exp_score(0));

    // back to ARMED
    frames(16, 1'b1, "flash2_nocol");
    chk("flash2_end", 16'(bus.hitFlash), 16'd0);

    // overlap coinciding with frame start: commit one frame later
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("coincide_col", 16'(bus.bonusFireCollision), 16'd0);
    idle();
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_outs("coincide_hit", 1'b1, 1'b1, 1'b1, exp_score(0));
    frames(16, 1'b0, "");

    // playGame dropped in HIT_PENDING
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_outs("play_drop", 1'b0, 1'b0, 1'b0, 9'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("play_drop_sof1", 16'(bus.bonusFireCollision), 16'd0);
    idle();
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("play_drop_sof2", 16'(bus.bonusFireCollision), 16'd0);

    // reset asserted mid-FLASH, asynchronously
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("pre_reset_hit", 16'(bus.bonusFireCollision), 16'd1);
    frames(3, 1'b0, "");
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk_outs("async_reset", 1'b0, 1'b0, 1'b0, 9'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    // state is IDLE: an overlap before any frame start must not arm a hit
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk_outs("post_reset", 1'b0, 1'b0, 1'b0, 9'd0);
    frames(3, 1'b1, "post_reset_nocol");

    // reset during HIT_PENDING discards the hit
    frames(1, 1'b0, "");
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    do_reset();
    frames(3, 1'b1, "reset_pending_nocol");

`ifdef BONUS_SHOT_TABLE_EN
    // 16 shots wrap the count to 1
    do_reset();
    frames(1, 1'b0, "");
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      idle();
    end
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_outs("shots16", 1'b1, 1'b1, 1'b1, exp_score(1));

    // fire in the commit clk uses the old count; the next hit sees the new one
    do_reset();
    frames(1, 1'b0, "");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    end
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_outs("fire_at_commit", 1'b1, 1'b1, 1'b1, exp_score(3));
    frames(16, 1'b0, "");
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_outs("after_commit_fire", 1'b1, 1'b1, 1'b1, exp_score(4));
`else
    // without the table, shots do not change the score
    do_reset();
    frames(1, 1'b0, "");
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    end
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_outs("fixed_score", 1'b1, 1'b1, 1'b1, 9'd100);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bonus_hit_ctrl.md
BONUS_HIT_CTRL -- requirements
Module: bonus_hit_ctrl

Interface
REQ-001 Parameter FLASH_FRAMES, default 16: number of frames hitFlash stays high after a hit (range 1..255).
REQ-002 Parameter FIXED_SCORE, default 100: score awarded when BONUS_SHOT_TABLE_EN is undefined.
REQ-003 clk  input  1  system clock; the block uses one clock; reset is asynchronous and active-high.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 startOfFrame  input  1  one-clk pulse at the start of every frame.
REQ-006 playGame  input  1  high while a game is running.
REQ-007 bonus_ship_DR  input  1  bonus ship drawing request for the current pixel.
REQ-008 playerShot_DR  input  1  player shot drawing request for the current pixel.
REQ-009 playerFire  input  1  one-clk pulse for each new player shot.
REQ-010 bonusFireCollision  output  1  one-clk hit pulse for the bonus ship.
REQ-011 scoreValid  output  1  one-clk pulse qualifying bonusScore.
REQ-012 bonusScore  output  9  points awarded, held until the next scoreValid.
REQ-013 hitFlash  output  1  explosion-display enable.

Function
REQ-014 The FSM SHALL have states IDLE, ARMED, HIT_PENDING and FLASH.
REQ-015 Any state SHALL go to IDLE on the clk after playGame is sampled low; in IDLE, outputs are 0 and shotCnt is 0.
REQ-016 IDLE SHALL go to ARMED on the first startOfFrame with playGame high.
REQ-017 ARMED SHALL go to HIT_PENDING on any clk with bonus_ship_DR & playerShot_DR high (pixel overlap).
REQ-018 In HIT_PENDING, further overlaps SHALL be ignored; the next startOfFrame SHALL commit the hit.
REQ-019 On commit, bonusFireCollision and scoreValid SHALL be high for exactly that one clk, bonusScore SHALL be loaded, hitFlash SHALL go high, flashCnt SHALL load FLASH_FRAMES-1, and the state SHALL become FLASH.
REQ-020 Latency: bonusFireCollision SHALL assert exactly 1 clk after the first startOfFrame that follows the overlap.
REQ-021 In FLASH, each startOfFrame with flashCnt>0 SHALL decrement flashCnt; startOfFrame with flashCnt==0 SHALL clear hitFlash and return to ARMED.
REQ-022 Overlaps in FLASH or IDLE SHALL be ignored.
REQ-023 If overlap and startOfFrame coincide in ARMED, the SHALL go to HIT_PENDING; commit occurs at the following startOfFrame.
REQ-024 shotCnt (4 bit) SHALL increment on playerFire while playGame is high, wrapping 14->0.
REQ-025 bonusScore SHALL use the shotCnt value before any same-clk playerFire increment.
REQ-026 shotCnt SHALL NOT reset on a hit.

Reset
REQ-027 Reset SHALL immediately force state IDLE, shotCnt=0, flashCnt=0, bonusScore=0, and all 1-bit outputs to 0.
REQ-028 Reset during FLASH or HIT_PENDING SHALL discard the pending hit, with no pulse after release.

Configuration
REQ-029 With BONUS_SHOT_TABLE_EN defined, bonusScore SHALL be SCORE_TABLE[shotCnt] (15 entries, each a multiple of 50, max 300).
REQ-030 Without BONUS_SHOT_TABLE_EN, bonusScore SHALL be FIXED_SCORE and shotCnt logic SHALL be omitted.

Structure
REQ-031 Package bonus_hit_pkg SHALL hold the state enum, SCORE_TABLE, SCORE_W=9 and SHOT_CNT_MAX=14.
REQ-032 One combinational sub-module bonus_score_lut (shotCnt -> score) SHALL be instantiated only under BONUS_SHOT_TABLE_EN.

Verification
REQ-033 Reset asserted mid-FLASH, then released -> all outputs 0 and state IDLE; no bonusFireCollision for 3 following frames.
REQ-034 playGame=1; one overlap pixel in frame N -> bonusFireCollision and scoreValid high for 1 clk, exactly 1 clk after the startOfFrame of frame N+1; hitFlash high for 16 frames.
REQ-035 Second overlap during FLASH -> no second pulse; a new overlap after FLASH ends -> new pulse.
REQ-036 BONUS_SHOT_TABLE_EN defined; 16 playerFire pulses then a hit -> bonusScore=SCORE_TABLE[1]; undefined -> bonusScore=100.
REQ-037 playerFire in the same clk as the commit with shotCnt=3 -> bonusScore=SCORE_TABLE[3], shotCnt becomes 4.
REQ-038 playGame dropped in HIT_PENDING -> IDLE on next clk; no pulse at the next startOfFrame.
